// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel reader: RGB struct,
// palette index width, the see-through index and the power-up palette.
package sprite_pkg;

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'd0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PALETTE [16] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'hFF8000,
        24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'h0000FF,
        24'h8000FF, 24'hFF00FF, 24'h808080, 24'hC0C0C0,
        24'h804000, 24'h004080, 24'h408000, 24'h202020
    };

endpackage

// File: rtl/sprite_palette.sv
// Writable 16-entry colour palette: reset loads the default table,
// one write port, combinational read (a same-edge write is seen next cycle).
module sprite_palette
    import sprite_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  rgb_t             wdata,
    input  logic [IDX_W-1:0] raddr,
    output rgb_t             rdata
);

    rgb_t mem [16];

    // Palette storage: default load on reset, otherwise single-entry write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem <= DEFAULT_PALETTE;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_pixel_reader.sv
// Three-stage pix_en-gated pipeline: drive the sprite index ROM, resolve the
// index through the palette, composite over background, count opaque pixels.
module sprite_pixel_reader
    import sprite_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int SPRITE_DEPTH = 16384,
    parameter int CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_en,
    input  logic              frame_start,
    input  logic              in_blank,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              is_sprite,
    input  logic [ADDR_W-1:0] sprite_addr,
    input  logic [23:0]       bg_rgb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_data,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_waddr,
    input  logic [23:0]       pal_wdata,
    output logic              out_valid,
    output logic [9:0]        out_X,
    output logic [9:0]        out_Y,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic [CNT_W-1:0]  opaque_cnt_last
);

    // One extra bit so a depth of exactly 2**ADDR_W is representable
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(SPRITE_DEPTH);

    logic             s1_hit, s1_blank, s1_fs;
    rgb_t             s1_bg;
    logic [9:0]       s1_x, s1_y;
    logic             s2_hit, s2_blank, s2_fs;
    logic [IDX_W-1:0] s2_idx;
    rgb_t             s2_bg;
    logic [9:0]       s2_x, s2_y;
    logic [1:0]       fill;
    logic [CNT_W-1:0] run_cnt, run_next;
    rgb_t             pal_rgb, px_rgb;
    logic             opaque;

    sprite_palette u_palette (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (pal_we),
        .waddr (pal_waddr),
        .wdata (pal_wdata),
        .raddr (s2_idx),
        .rdata (pal_rgb)
    );

    // Output colour selection and saturating next value of the opaque count
    always_comb begin
        px_rgb = 24'h000000;
        opaque = 1'b0;
        if (s2_blank) begin
            px_rgb = 24'h000000;
        end else if (s2_hit && (s2_idx != TRANSPARENT_IDX)) begin
            px_rgb = pal_rgb;
            opaque = 1'b1;
        end else begin
            px_rgb = s2_bg;
        end
        if (opaque && (run_cnt != {CNT_W{1'b1}})) begin
            run_next = run_cnt + CNT_W'(1);
        end else begin
            run_next = run_cnt;
        end
    end

    // Pipeline stages, output register and per-frame counter, all gated by pix_en
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr        <= {ADDR_W{1'b0}};
            s1_hit          <= 1'b0;
            s1_blank        <= 1'b0;
            s1_fs           <= 1'b0;
            s1_bg           <= 24'h000000;
            s1_x            <= 10'd0;
            s1_y            <= 10'd0;
            s2_hit          <= 1'b0;
            s2_blank        <= 1'b0;
            s2_fs           <= 1'b0;
            s2_idx          <= {IDX_W{1'b0}};
            s2_bg           <= 24'h000000;
            s2_x            <= 10'd0;
            s2_y            <= 10'd0;
            VGA_R           <= 8'd0;
            VGA_G           <= 8'd0;
            VGA_B           <= 8'd0;
            out_X           <= 10'd0;
            out_Y           <= 10'd0;
            out_valid       <= 1'b0;
            fill            <= 2'd0;
            run_cnt         <= {CNT_W{1'b0}};
            opaque_cnt_last <= {CNT_W{1'b0}};
        end else if (pix_en) begin
            rom_addr <= sprite_addr;
            s1_hit   <= is_sprite && ({1'b0, sprite_addr} < DEPTH_LIM) && !in_blank;
            s1_blank <= in_blank;
            s1_fs    <= frame_start;
            s1_bg    <= bg_rgb;
            s1_x     <= DrawX;
            s1_y     <= DrawY;

            s2_idx   <= rom_data;
            s2_hit   <= s1_hit;
            s2_blank <= s1_blank;
            s2_fs    <= s1_fs;
            s2_bg    <= s1_bg;
            s2_x     <= s1_x;
            s2_y     <= s1_y;

            VGA_R     <= px_rgb.r;
            VGA_G     <= px_rgb.g;
            VGA_B     <= px_rgb.b;
            out_X     <= s2_x;
            out_Y     <= s2_y;
            out_valid <= (fill == 2'd2);
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end

            // The frame-start pixel still belongs to the frame being closed
            if (s2_fs) begin
                opaque_cnt_last <= run_next;
                run_cnt         <= {CNT_W{1'b0}};
            end else begin
                run_cnt <= run_next;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Scoreboard bench for sprite_pixel_reader: a transaction-level model predicts
// each output pixel, a negedge monitor pops and compares as pixels appear.
module tb_sprite_pixel_reader;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 8000;
    localparam int CNT_W  = 16;

    localparam logic [23:0] DEF_PAL [16] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'hFF8000,
        24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'h0000FF,
        24'h8000FF, 24'hFF00FF, 24'h808080, 24'hC0C0C0,
        24'h804000, 24'h004080, 24'h408000, 24'h202020
    };

    logic              Clk = 1'b0;
    logic              Reset, pix_en, frame_start, in_blank, is_sprite;
    logic [9:0]        DrawX, DrawY, out_X, out_Y;
    logic [ADDR_W-1:0] sprite_addr, rom_addr;
    logic [23:0]       bg_rgb, pal_wdata;
    logic [3:0]        rom_data, pal_waddr;
    logic              pal_we, out_valid;
    logic [7:0]        VGA_R, VGA_G, VGA_B;
    logic [CNT_W-1:0]  opaque_cnt_last;

    sprite_pixel_reader #(.ADDR_W(ADDR_W), .SPRITE_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .frame_start(frame_start),
        .in_blank(in_blank), .DrawX(DrawX), .DrawY(DrawY), .is_sprite(is_sprite),
        .sprite_addr(sprite_addr), .bg_rgb(bg_rgb), .rom_addr(rom_addr),
        .rom_data(rom_data), .pal_we(pal_we), .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata), .out_valid(out_valid), .out_X(out_X), .out_Y(out_Y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .opaque_cnt_last(opaque_cnt_last)
    );

    always #10 Clk = ~Clk;

    // Sprite index ROM: data settles within the cycle after rom_addr is registered
    logic [3:0] rom [0:16383];
    assign rom_data = rom[rom_addr];

    typedef struct {
        logic        hit;
        logic [3:0]  idx;
        logic        blank;
        logic [23:0] bg;
        logic [9:0]  x, y;
        logic        fs;
    } px_t;

    typedef struct {
        logic [23:0] rgb;
        logic [9:0]  x, y;
        logic [15:0] cnt;
    } exp_t;

    px_t         inflight[$];
    exp_t        sb[$];
    logic [23:0] mpal [16];
    logic [15:0] m_run, m_last;
    int          compared = 0;
    int          mismatched = 0;

    localparam int K_RESET = 1, K_SNAP = 2, K_STALL = 3, K_CNT = 4, K_DRAIN = 5;
    int          probe_id = 0;
    int          probe_kind = 0;
    int          seen_id = 0;
    logic [43:0] snap;
    exp_t        me;

    task automatic model_reset();
        inflight.delete();
        sb.delete();
        for (int i = 0; i < 16; i++) mpal[i] = DEF_PAL[i];
        m_run  = 16'd0;
        m_last = 16'd0;
    endtask

    // Drive one cycle; every pixel emerges on the third pix_en strobe that carries it
    task automatic step(input logic en, input logic sp, input logic [13:0] a,
                        input logic blk, input logic fs, input logic we,
                        input logic [3:0] wa, input logic [23:0] wd);
        px_t  p, o;
        exp_t e;
        pix_en      = en;
        is_sprite   = sp;
        sprite_addr = a;
        in_blank    = blk;
        frame_start = fs & en;
        bg_rgb      = 24'($urandom);
        DrawX       = 10'($urandom);
        DrawY       = 10'($urandom);
        pal_we      = we;
        pal_waddr   = wa;
        pal_wdata   = wd;
        if (en) begin
            p.hit = sp && (int'(a) < DEPTH) && !blk;
            p.idx = rom[a];
            p.blank = blk;
            p.bg = bg_rgb;
            p.x = DrawX;
            p.y = DrawY;
            p.fs = fs;
            inflight.push_back(p);
            if (inflight.size() == 3) begin
                o = inflight.pop_front();
                if (o.blank) e.rgb = 24'h000000;
                else if (o.hit && o.idx != 4'd0) begin
                    e.rgb = mpal[o.idx];
                    if (m_run != 16'hFFFF) m_run = m_run + 16'd1;
                end else e.rgb = o.bg;
                if (o.fs) begin
                    m_last = m_run;
                    m_run  = 16'd0;
                end
                e.x = o.x;
                e.y = o.y;
                e.cnt = m_last;
                sb.push_back(e);
            end
        end
        if (we) mpal[wa] = wd;
        @(posedge Clk);
        #1;
    endtask

    task automatic px(input logic sp, input logic [13:0] a, input logic blk, input logic fs);
        step(1'b1, sp, a, blk, fs, 1'b0, 4'd0, 24'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0);
    endtask

    task automatic probe(input int kind);
        probe_kind = kind;
        probe_id   = probe_id + 1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle();
        model_reset();
        Reset = 1'b0;
        probe(K_RESET);
    endtask

    // Monitor: scoreboard pops on every valid output plus directed probes
    always @(negedge Clk) begin
        if (out_valid) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pixel: out_valid=1 x=%0d y=%0d but no pixel is due", out_X, out_Y);
            end else begin
                me = sb.pop_front();
                if ({VGA_R, VGA_G, VGA_B} !== me.rgb || out_X !== me.x || out_Y !== me.y ||
                    opaque_cnt_last !== me.cnt) begin
                    mismatched++;
                    $display("FAIL pixel: got rgb=%h x=%0d y=%0d cnt=%0d, expected rgb=%h x=%0d y=%0d cnt=%0d",
                             {VGA_R, VGA_G, VGA_B}, out_X, out_Y, opaque_cnt_last,
                             me.rgb, me.x, me.y, me.cnt);
                end
            end
        end
        if (probe_id != seen_id) begin
            seen_id = probe_id;
            case (probe_kind)
                K_RESET: begin
                    compared++;
                    if (out_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'h0 || out_X !== 10'd0 ||
                        out_Y !== 10'd0 || opaque_cnt_last !== 16'd0 || rom_addr !== 14'd0) begin
                        mismatched++;
                        $display("FAIL reset_state: got valid=%b rgb=%h x=%0d y=%0d cnt=%0d rom_addr=%0d, expected all 0",
                                 out_valid, {VGA_R, VGA_G, VGA_B}, out_X, out_Y, opaque_cnt_last, rom_addr);
                    end
                end
                K_SNAP: snap = {VGA_R, VGA_G, VGA_B, out_X, out_Y};
                K_STALL: begin
                    compared++;
                    if (out_valid !== 1'b0 || {VGA_R, VGA_G, VGA_B, out_X, out_Y} !== snap) begin
                        mismatched++;
                        $display("FAIL stall_hold: got valid=%b outputs=%h, expected valid=0 outputs=%h",
                                 out_valid, {VGA_R, VGA_G, VGA_B, out_X, out_Y}, snap);
                    end
                end
                K_CNT: begin
                    compared++;
                    if (opaque_cnt_last !== 16'd10) begin
                        mismatched++;
                        $display("FAIL frame_count: got %0d, expected 10", opaque_cnt_last);
                    end
                end
                K_DRAIN: begin
                    compared++;
                    if (sb.size() != 0) begin
                        mismatched++;
                        $display("FAIL drain: %0d expected pixels never appeared, expected 0", sb.size());
                    end
                end
                default: ;
            endcase
        end
    end

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 4'($urandom);
        rom[5] = 4'd3;  rom[7] = 4'd0;  rom[7999] = 4'd9;
        rom[8000] = 4'd3; rom[9000] = 4'd3; rom[16383] = 4'd3;
        Reset = 1'b1;
        model_reset();
        idle();
        idle();
        do_reset();

        // Opaque, transparent, non-sprite, blank and address-range boundaries
        repeat (4) px(1'b1, 14'd5, 1'b0, 1'b0);
        px(1'b1, 14'd7, 1'b0, 1'b0);
        px(1'b0, 14'd7, 1'b0, 1'b0);
        px(1'b0, 14'd5, 1'b0, 1'b0);
        px(1'b1, 14'd5, 1'b1, 1'b0);
        px(1'b1, 14'd7999, 1'b0, 1'b0);
        px(1'b1, 14'd8000, 1'b0, 1'b0);
        px(1'b1, 14'd9000, 1'b0, 1'b0);
        px(1'b1, 14'd16383, 1'b0, 1'b0);

        // Palette write to entry 3 while entry 3 is being read
        repeat (3) px(1'b1, 14'd5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 14'd5, 1'b0, 1'b0, 1'b1, 4'd3, 24'h00FF00);
        repeat (3) px(1'b1, 14'd5, 1'b0, 1'b0);

        // A frame of exactly ten opaque pixels
        px(1'b0, 14'd0, 1'b0, 1'b1);
        repeat (10) px(1'b1, 14'd5, 1'b0, 1'b0);
        px(1'b0, 14'd0, 1'b0, 1'b1);
        repeat (3) px(1'b0, 14'd0, 1'b0, 1'b0);
        probe(K_CNT);

        // Alternating strobes, then a 5-cycle stall
        for (int i = 0; i < 8; i++) begin
            px(1'b1, 14'($urandom_range(0, 31)), 1'b0, 1'b0);
            idle();
        end
        px(1'b1, 14'd5, 1'b0, 1'b0);
        probe(K_SNAP);
        repeat (5) idle();
        probe(K_STALL);

        // Reset in the middle of a stream
        repeat (5) px(1'b1, 14'd5, 1'b0, 1'b0);
        do_reset();
        repeat (6) px(1'b1, 14'($urandom_range(0, 63)), 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [13:0] a;
            case ($urandom_range(0, 3))
                0: a = 14'($urandom_range(0, 31));
                1: a = 14'($urandom_range(7990, 8010));
                2: a = 14'($urandom);
                default: a = 14'd5;
            endcase
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0), a,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) == 0), 4'($urandom), 24'($urandom));
        end

        repeat (3) px(1'b0, 14'd0, 1'b0, 1'b0);
        idle();
        probe(K_DRAIN);
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
